// File: rtl/usb_rx_dpll_pkg.sv
// usb_rx_dpll_pkg
//   Shared types for the USB receive front end: line state and receiver
//   state encodings, the default speed selection, and the pin-pair to
//   line-state decode.
//   No ports (package).
package usb_rx_dpll_pkg;

  localparam bit USB_FULL_SPEED = 1'b1;

  typedef enum logic [1:0] {
    SE0 = 2'b00,
    J   = 2'b01,
    K   = 2'b10,
    SE1 = 2'b11
  } line_state_t;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACTIVE = 2'b01,
    EOP    = 2'b10
  } rx_state_t;

  // Full speed idles with D+ high, low speed idles with D- high.
  function automatic line_state_t decode_line(input logic dp, input logic dm,
                                              input bit fs);
    line_state_t ls;
    case ({dp, dm})
      2'b00:   ls = SE0;
      2'b11:   ls = SE1;
      2'b10:   ls = fs ? J : K;
      default: ls = fs ? K : J;
    endcase
    return ls;
  endfunction

endpackage

// File: rtl/usb_rx_dpll_sync2.sv
// usb_sync2
//   Two-flop synchroniser for one asynchronous pin.
//   Ports:
//     clk_i   in  synchroniser clock
//     rst_ni  in  asynchronous reset, active low (flops load RST_VAL)
//     d_i     in  asynchronous input
//     q_o     out synchronised output
module usb_sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= d_i;
      r_sync <= r_meta;
    end
  end

  assign q_o = r_sync;

endmodule

// File: rtl/usb_rx_dpll.sv
// usb_rx_dpll
//   USB receive front end running at 4x the bit rate. Synchronises D+/D-,
//   decodes the line state, recovers bit centres with a 4-phase DPLL, tracks
//   packet activity from the first K to EOP, and detects bus reset.
//   Ports:
//     clk_i        in   clk_usb, 4x bit rate
//     rst_ni       in   asynchronous reset, active low
//     dp_i, dm_i   in   raw D+/D- pins (asynchronous)
//     line_o       out  synchronised line state
//     strobe_o     out  one-clock pulse at recovered bit centre
//     bit_o        out  sampled level (1 = J), valid with strobe_o, held after
//     rx_active_o  out  packet in progress
//     eop_o        out  one-clock pulse on a valid EOP
//     rx_err_o     out  one-clock pulse on SE1 or malformed EOP
//     usb_reset_o  out  SE0 held for RESET_CYCLES clocks
//
//   Receiver states (advance on strobe only; bus reset forces IDLE):
//     state  | meaning
//     IDLE   | bus idle, waiting for the first K of SYNC
//     ACTIVE | packet in progress
//     EOP    | SE0 seen, expecting at most one more SE0 then J
module usb_rx_dpll
  import usb_rx_dpll_pkg::*;
#(
  parameter bit FULL_SPEED   = USB_FULL_SPEED,
  parameter int RESET_CYCLES = FULL_SPEED ? 120 : 15
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        dp_i,
  input  logic        dm_i,
  output line_state_t line_o,
  output logic        strobe_o,
  output logic        bit_o,
  output logic        rx_active_o,
  output logic        eop_o,
  output logic        rx_err_o,
  output logic        usb_reset_o
);

  localparam int CW = $clog2(RESET_CYCLES + 1);
  localparam logic [CW-1:0] RST_CNT = CW'(RESET_CYCLES);

  logic        w_dp;
  logic        w_dm;
  line_state_t w_line;
  logic        w_edge;
  logic        w_strobe;
  logic        w_is_j;
  logic        w_usb_reset;

  line_state_t r_line_q;
  logic [1:0]  r_phase;
  logic        r_bit;
  logic [CW-1:0] r_se0_cnt;
  rx_state_t   r_state;
  logic [1:0]  r_eop_cnt;
  logic        r_active;
  logic        r_eop;
  logic        r_err;

  // Flops reset to the idle (J) level so release never fakes an edge.
  usb_sync2 #(.RST_VAL(FULL_SPEED)) u_sync_dp (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (dp_i),
    .q_o    (w_dp)
  );

  usb_sync2 #(.RST_VAL(!FULL_SPEED)) u_sync_dm (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (dm_i),
    .q_o    (w_dm)
  );

  assign w_line   = decode_line(w_dp, w_dm, FULL_SPEED);
  assign w_edge   = (w_line != r_line_q);
  assign w_strobe = (r_phase == 2'd2);
  assign w_is_j   = (w_line == J);

  // Edge reloads phase 1 so the next strobe lands two clocks later, mid-bit.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_line_q <= J;
      r_phase  <= 2'd0;
      r_bit    <= 1'b0;
    end else begin
      r_line_q <= w_line;
      r_phase  <= w_edge ? 2'd1 : r_phase + 2'd1;
      if (w_strobe) r_bit <= w_is_j;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_se0_cnt <= '0;
    end else if (w_line == SE0) begin
      if (r_se0_cnt != RST_CNT) r_se0_cnt <= r_se0_cnt + 1'b1;
    end else begin
      r_se0_cnt <= '0;
    end
  end

  assign w_usb_reset = (r_se0_cnt == RST_CNT);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= IDLE;
      r_eop_cnt <= 2'd0;
      r_active  <= 1'b0;
      r_eop     <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_eop <= 1'b0;
      r_err <= 1'b0;
      if (w_usb_reset) begin
        r_state   <= IDLE;
        r_eop_cnt <= 2'd0;
        r_active  <= 1'b0;
      end else if (w_strobe) begin
        case (r_state)
          IDLE: begin
            if (w_line == K) begin
              r_state  <= ACTIVE;
              r_active <= 1'b1;
            end
          end
          ACTIVE: begin
            case (w_line)
              SE0: begin
                r_state   <= EOP;
                r_eop_cnt <= 2'd1;
              end
              SE1: begin
                r_state  <= IDLE;
                r_active <= 1'b0;
                r_err    <= 1'b1;
              end
              default: ;
            endcase
          end
          EOP: begin
            case (w_line)
              SE0: begin
                if (r_eop_cnt == 2'd2) begin
                  r_state  <= IDLE;
                  r_active <= 1'b0;
                  r_err    <= 1'b1;
                end else begin
                  r_eop_cnt <= r_eop_cnt + 2'd1;
                end
              end
              J: begin
                r_state  <= IDLE;
                r_active <= 1'b0;
                r_eop    <= 1'b1;
              end
              default: begin
                r_state  <= IDLE;
                r_active <= 1'b0;
                r_err    <= 1'b1;
              end
            endcase
          end
          default: begin
            r_state  <= IDLE;
            r_active <= 1'b0;
          end
        endcase
      end
    end
  end

  assign line_o      = w_line;
  assign strobe_o    = w_strobe;
  assign bit_o       = w_strobe ? w_is_j : r_bit;
  assign rx_active_o = r_active;
  assign eop_o       = r_eop;
  assign rx_err_o    = r_err;
  assign usb_reset_o = w_usb_reset;

endmodule

// File: tb/tb_usb_rx_dpll.sv
// tb_usb_rx_dpll
//   Directed bench for usb_rx_dpll at full speed. Each clock is logged after
//   the active edge; expected cycles are derived from the cycle at which each
//   line symbol was driven (line_o follows 2 clocks later, strobe 2 after that).
module tb_usb_rx_dpll;

  localparam logic [1:0] L_SE0 = 2'b00;
  localparam logic [1:0] L_J   = 2'b01;
  localparam logic [1:0] L_K   = 2'b10;
  localparam logic [1:0] L_SE1 = 2'b11;
  localparam int NLOG = 2048;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       dp_i;
  logic       dm_i;
  logic [1:0] line_o;
  logic       strobe_o;
  logic       bit_o;
  logic       rx_active_o;
  logic       eop_o;
  logic       rx_err_o;
  logic       usb_reset_o;

  usb_rx_dpll dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .dp_i        (dp_i),
    .dm_i        (dm_i),
    .line_o      (line_o),
    .strobe_o    (strobe_o),
    .bit_o       (bit_o),
    .rx_active_o (rx_active_o),
    .eop_o       (eop_o),
    .rx_err_o    (rx_err_o),
    .usb_reset_o (usb_reset_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  logic s_log [0:NLOG-1];
  logic b_log [0:NLOG-1];
  logic a_log [0:NLOG-1];
  logic e_log [0:NLOG-1];
  logic x_log [0:NLOG-1];
  logic r_log [0:NLOG-1];

  int         sc [0:63];
  logic [1:0] ss [0:63];
  int         nsym = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
    cyc++;
    if (cyc < NLOG) begin
      s_log[cyc] = strobe_o;
      b_log[cyc] = bit_o;
      a_log[cyc] = rx_active_o;
      e_log[cyc] = eop_o;
      x_log[cyc] = rx_err_o;
      r_log[cyc] = usb_reset_o;
    end
  endtask

  task automatic drive(input logic [1:0] s);
    case (s)
      L_J:     begin dp_i = 1'b1; dm_i = 1'b0; end
      L_K:     begin dp_i = 1'b0; dm_i = 1'b1; end
      L_SE0:   begin dp_i = 1'b0; dm_i = 1'b0; end
      default: begin dp_i = 1'b1; dm_i = 1'b1; end
    endcase
  endtask

  task automatic send(input logic [1:0] s, input int w);
    sc[nsym] = cyc;
    ss[nsym] = s;
    nsym++;
    drive(s);
    repeat (w) step();
  endtask

  // Start new traffic right after a strobe so no stray strobe can land on
  // the first line edge.
  task automatic align();
    for (int k = 0; k < 4 && s_log[cyc] !== 1'b1; k++) step();
  endtask

  function automatic int cnt(input int which, input int lo, input int hi);
    int n = 0;
    for (int k = lo; k <= hi; k++) begin
      case (which)
        0: n += int'(s_log[k]);
        1: n += int'(a_log[k]);
        2: n += int'(e_log[k]);
        3: n += int'(x_log[k]);
        default: n += int'(r_log[k]);
      endcase
    end
    return n;
  endfunction

  // Symbol i expects exactly one strobe in its window, at drive cycle + 4.
  task automatic chk_bit(input int i, input string tag);
    chk($sformatf("%s[%0d] strobes", tag, i), cnt(0, sc[i] + 3, sc[i+1] + 2), 1);
    chk($sformatf("%s[%0d] strobe_pos", tag, i), s_log[sc[i] + 4], 1);
    chk($sformatf("%s[%0d] bit", tag, i), b_log[sc[i] + 4], (ss[i] == L_J));
  endtask

  initial begin
    int last;
    int nstb;
    int p0;
    int base;
    int s;
    int a;

    rst_ni = 1'b1;
    drive(L_J);
    #1 rst_ni = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst line", line_o, L_J);
    chk("rst strobe", strobe_o, 0);
    chk("rst bit", bit_o, 0);
    chk("rst active", rx_active_o, 0);
    chk("rst eop", eop_o, 0);
    chk("rst err", rx_err_o, 0);
    chk("rst usb_reset", usb_reset_o, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Idle J: strobe every 4 clocks, J sampled, nothing else.
    repeat (40) step();
    last = 0;
    nstb = 0;
    for (int k = 1; k <= 40; k++) begin
      if (s_log[k] === 1'b1) begin
        nstb++;
        chk("idle bit", b_log[k], 1);
        if (last > 0) chk("idle period", k - last, 4);
        last = k;
      end
    end
    chk("idle strobe count", nstb, 10);
    chk("idle active", cnt(1, 1, 40), 0);
    chk("idle eop", cnt(2, 1, 40), 0);
    chk("idle err", cnt(3, 1, 40), 0);

    // SYNC at 4 clk/bit, two data bits, SE0 x8, J -> valid EOP.
    align();
    p0 = cyc;
    base = nsym;
    send(L_K, 4); send(L_J, 4); send(L_K, 4); send(L_J, 4);
    send(L_K, 4); send(L_J, 4); send(L_K, 4); send(L_K, 4);
    send(L_J, 4); send(L_K, 4);
    send(L_SE0, 8);
    send(L_J, 12);
    for (int i = 0; i < 10; i++) chk_bit(base + i, "sync4");
    chk("sync4 active pre", a_log[sc[base] + 4], 0);
    chk("sync4 active rise", a_log[sc[base] + 5], 1);
    s = sc[base + 10];
    chk("eop se0 strobe1", s_log[s + 4], 1);
    chk("eop se0 bit1", b_log[s + 4], 0);
    chk("eop se0 strobe2", s_log[s + 8], 1);
    chk("eop pre", e_log[s + 12], 0);
    chk("eop pulse", e_log[s + 13], 1);
    chk("eop post", e_log[s + 14], 0);
    chk("eop active pre", a_log[s + 12], 1);
    chk("eop active fall", a_log[s + 13], 0);
    chk("eop count", cnt(2, p0 + 1, cyc), 1);
    chk("eop err count", cnt(3, p0 + 1, cyc), 0);

    // Jittered SYNC, then SE0 x8 followed by K -> malformed EOP.
    align();
    p0 = cyc;
    base = nsym;
    send(L_K, 3); send(L_J, 5); send(L_K, 4); send(L_J, 3);
    send(L_K, 5); send(L_J, 4); send(L_K, 4); send(L_K, 4);
    send(L_SE0, 8);
    send(L_K, 4);
    send(L_J, 12);
    for (int i = 0; i < 8; i++) chk_bit(base + i, "jit");
    s = sc[base + 8];
    chk("bad eop active pre", a_log[s + 12], 1);
    chk("bad eop err", x_log[s + 13], 1);
    chk("bad eop active fall", a_log[s + 13], 0);
    chk("bad eop err count", cnt(3, p0 + 1, cyc), 1);
    chk("bad eop eop count", cnt(2, p0 + 1, cyc), 0);

    // SE1 mid-packet.
    align();
    p0 = cyc;
    base = nsym;
    send(L_K, 4); send(L_J, 4); send(L_SE1, 4); send(L_J, 12);
    a = sc[base];
    chk("se1 active pre", a_log[a + 4], 0);
    chk("se1 active rise", a_log[a + 5], 1);
    chk("se1 active held", a_log[a + 12], 1);
    chk("se1 err", x_log[a + 13], 1);
    chk("se1 active fall", a_log[a + 13], 0);
    chk("se1 err count", cnt(3, p0 + 1, cyc), 1);
    chk("se1 eop count", cnt(2, p0 + 1, cyc), 0);

    // Bus reset: SE0 for 130 clocks then J.
    align();
    s = cyc;
    send(L_SE0, 130);
    send(L_J, 12);
    chk("busrst pre", r_log[s + 121], 0);
    chk("busrst rise", r_log[s + 122], 1);
    chk("busrst held", r_log[s + 132], 1);
    chk("busrst fall", r_log[s + 133], 0);
    chk("busrst length", cnt(4, s + 1, cyc), 11);
    chk("busrst eop", cnt(2, s + 1, cyc), 0);
    chk("busrst err", cnt(3, s + 1, cyc), 0);
    chk("busrst active", cnt(1, s + 1, cyc), 0);

    // Asynchronous reset in the middle of a packet.
    align();
    send(L_K, 4);
    send(L_J, 4);
    chk("mid active", rx_active_o, 1);
    drive(L_K);
    #2 rst_ni = 1'b0;
    #1;
    chk("arst line", line_o, L_J);
    chk("arst strobe", strobe_o, 0);
    chk("arst bit", bit_o, 0);
    chk("arst active", rx_active_o, 0);
    chk("arst eop", eop_o, 0);
    chk("arst err", rx_err_o, 0);
    chk("arst usb_reset", usb_reset_o, 0);
    #20 rst_ni = 1'b1;
    repeat (3) @(posedge clk_i);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
